// File: rtl/nn_pkg.sv
// Shared types and sizing helpers for the two-layer
// fully connected network sequencer.
package nn_pkg;

  localparam int N_IN_DEF   = 4;
  localparam int N_HID_DEF  = 3;
  localparam int N_OUT_DEF  = 2;
  localparam int IDX_W_DEF  = 8;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_L1_CLR = 4'd1,
    S_L1_MAC = 4'd2,
    S_L1_ACT = 4'd3,
    S_L1_WR  = 4'd4,
    S_L2_CLR = 4'd5,
    S_L2_MAC = 4'd6,
    S_L2_ACT = 4'd7,
    S_L2_WR  = 4'd8,
    S_DONE   = 4'd9
  } state_t;

  // Total number of weights across both layers.
  function automatic int weight_count(
    input int n_in,
    input int n_hid,
    input int n_out
  );
    return n_in * n_hid + n_hid * n_out;
  endfunction

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/nn_loop_counter.sv
// Loadable up-counter with enable and a programmable terminal count.
// Ports: clk, reset_n, load/load_val, en, term -> count, last (count==term).
module nn_loop_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         last
);

  assign last = (count == term);

  // Wrapping to zero at the terminal count leaves the counter
  // ready for the next loop without an explicit reload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= last ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Stallable, restartable sequencer driving a single-MAC datapath
// through a two-layer fully connected network.
// Ports: clk, reset_n, start, abort, in_valid -> busy, layer_sel,
//   acc_clear, mac_en, in_idx, neuron_idx, weight_addr, act_en,
//   wr_en, done, result_ready.
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int N_HID  = N_HID_DEF,
  parameter int N_OUT  = N_OUT_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              busy,
  output logic              layer_sel,
  output logic              acc_clear,
  output logic              mac_en,
  output logic [IDX_W-1:0]  in_idx,
  output logic [IDX_W-1:0]  neuron_idx,
  output logic [ADDR_W-1:0] weight_addr,
  output logic              act_en,
  output logic              wr_en,
  output logic              done,
  output logic              result_ready
);

  localparam int WCNT    = weight_count(N_IN, N_HID, N_OUT);
  localparam int IDX_MAX = max3(N_IN, N_HID, N_OUT);

  state_t state;
  state_t state_nx;

  logic              done_q;
  logic              is_mac;
  logic              go;
  logic              clr_all;
  logic              in_last;
  logic              nr_last;
  logic [IDX_W-1:0]  in_term;
  logic [IDX_W-1:0]  nr_term;
  logic [ADDR_W-1:0] waddr;

  // State register; done_q marks the first cycle in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= (state_nx == S_DONE)
             && (state != S_DONE);
    end
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE,
        S_DONE: begin
          if (start) state_nx = S_L1_CLR;
        end
        S_L1_CLR: state_nx = S_L1_MAC;
        S_L1_MAC: begin
          if (in_valid && in_last)
            state_nx = S_L1_ACT;
        end
        S_L1_ACT: state_nx = S_L1_WR;
        S_L1_WR: begin
          state_nx = nr_last ? S_L2_CLR
                             : S_L1_CLR;
        end
        S_L2_CLR: state_nx = S_L2_MAC;
        S_L2_MAC: begin
          if (in_valid && in_last)
            state_nx = S_L2_ACT;
        end
        S_L2_ACT: state_nx = S_L2_WR;
        S_L2_WR: begin
          state_nx = nr_last ? S_DONE
                             : S_L2_CLR;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy         = 1'b1;
    layer_sel    = 1'b0;
    acc_clear    = 1'b0;
    is_mac       = 1'b0;
    act_en       = 1'b0;
    wr_en        = 1'b0;
    result_ready = 1'b0;
    unique case (state)
      S_IDLE: busy = 1'b0;
      S_L1_CLR: acc_clear = 1'b1;
      S_L1_MAC: is_mac = 1'b1;
      S_L1_ACT: act_en = 1'b1;
      S_L1_WR: wr_en = 1'b1;
      S_L2_CLR: begin
        layer_sel = 1'b1;
        acc_clear = 1'b1;
      end
      S_L2_MAC: begin
        layer_sel = 1'b1;
        is_mac    = 1'b1;
      end
      S_L2_ACT: begin
        layer_sel = 1'b1;
        act_en    = 1'b1;
      end
      S_L2_WR: begin
        layer_sel = 1'b1;
        wr_en     = 1'b1;
      end
      S_DONE: begin
        busy         = 1'b0;
        result_ready = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign mac_en = is_mac & in_valid;
  assign done   = done_q;

  // A fresh run or an abort zeroes every counter.
  assign go = ((state == S_IDLE)
            || (state == S_DONE))
            && start && !abort;
  assign clr_all = abort | go;

  assign in_term = layer_sel
    ? IDX_W'(N_HID - 1)
    : IDX_W'(N_IN - 1);
  assign nr_term = layer_sel
    ? IDX_W'(N_OUT - 1)
    : IDX_W'(N_HID - 1);

  nn_loop_counter #(
    .W (IDX_W)
  ) u_in_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (clr_all | acc_clear),
    .load_val ('0),
    .en       (mac_en),
    .term     (in_term),
    .count    (in_idx),
    .last     (in_last)
  );

  nn_loop_counter #(
    .W (IDX_W)
  ) u_nr_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (clr_all),
    .load_val ('0),
    .en       (wr_en),
    .term     (nr_term),
    .count    (neuron_idx),
    .last     (nr_last)
  );

  // Weights are laid out neuron-major with layer 2 directly after
  // layer 1, so one running counter covers both layers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      waddr <= '0;
    end else if (clr_all) begin
      waddr <= '0;
    end else if (mac_en) begin
      waddr <= waddr + ADDR_W'(1);
    end
  end

  assign weight_addr = waddr;

  a_addr_w_ok : assert property (
    @(posedge clk) (WCNT - 1) < (1 << ADDR_W)
  ) else $error("ADDR_W too narrow for weight count");

  a_idx_w_ok : assert property (
    @(posedge clk) (IDX_MAX - 1) < (1 << IDX_W)
  ) else $error("IDX_W too narrow for layer sizes");

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Randomized bench for nn_layer_sequencer against a step-list model
// built from the layer/neuron/input loop structure.
module tb_nn_layer_sequencer;

  localparam int N_IN    = 4;
  localparam int N_HID   = 3;
  localparam int N_OUT   = 2;
  localparam int IDX_W   = 8;
  localparam int ADDR_W  = 5;
  localparam int RUN_CYC = N_HID * (N_IN + 3) + N_OUT * (N_HID + 3);
  localparam int N_W     = N_IN * N_HID + N_HID * N_OUT;

  localparam int M_NOM   = 0;
  localparam int M_RAND  = 1;
  localparam int M_STALL = 2;
  localparam int M_ABORT = 3;
  localparam int M_RST   = 4;

  typedef enum int {K_CLR, K_MAC, K_ACT, K_WR} kind_e;
  typedef struct {
    kind_e k;
    int    l;
    int    n;
    int    i;
    int    a;
  } step_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              in_valid = 1'b0;
  logic              busy;
  logic              layer_sel;
  logic              acc_clear;
  logic              mac_en;
  logic [IDX_W-1:0]  in_idx;
  logic [IDX_W-1:0]  neuron_idx;
  logic [ADDR_W-1:0] weight_addr;
  logic              act_en;
  logic              wr_en;
  logic              done;
  logic              result_ready;

  int n_chk = 0;
  int n_pass = 0;

  nn_layer_sequencer #(
    .N_IN   (N_IN),
    .N_HID  (N_HID),
    .N_OUT  (N_OUT),
    .IDX_W  (IDX_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .in_valid     (in_valid),
    .busy         (busy),
    .layer_sel    (layer_sel),
    .acc_clear    (acc_clear),
    .mac_en       (mac_en),
    .in_idx       (in_idx),
    .neuron_idx   (neuron_idx),
    .weight_addr  (weight_addr),
    .act_en       (act_en),
    .wr_en        (wr_en),
    .done         (done),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] flags();
    return {busy, layer_sel, acc_clear, mac_en,
            act_en, wr_en, done, result_ready};
  endfunction

  function automatic logic [31:0] all_out();
    return {flags(), in_idx, neuron_idx, 3'b000, weight_addr};
  endfunction

  function automatic step_t mk(
    input kind_e k, input int l, input int n,
    input int i, input int a
  );
    step_t s;
    s.k = k; s.l = l; s.n = n; s.i = i; s.a = a;
    return s;
  endfunction

  task automatic idle_chk(input int cnt, input string tag);
    for (int k = 0; k < cnt; k++) begin
      @(posedge clk); #1;
      chk(tag, all_out(), 32'd0);
    end
  endtask

  task automatic run(input int mode);
    step_t q[$];
    step_t s;
    int a = 0;
    int cyc = 0;
    int stalls = 0;
    int hold = 5;
    bit cut = 0;
    logic [7:0] ef;
    for (int l = 0; l < 2; l++) begin
      int nn;
      int ni;
      nn = (l != 0) ? N_OUT : N_HID;
      ni = (l != 0) ? N_HID : N_IN;
      for (int n = 0; n < nn; n++) begin
        q.push_back(mk(K_CLR, l, n, 0, a));
        for (int i = 0; i < ni; i++) begin
          q.push_back(mk(K_MAC, l, n, i, a));
          a++;
        end
        q.push_back(mk(K_ACT, l, n, 0, a));
        q.push_back(mk(K_WR, l, n, 0, a));
      end
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (q.size() > 0 && cyc < 4 * RUN_CYC && !cut) begin
      s = q[0];
      if (s.k != K_MAC)
        in_valid = 1'($urandom_range(0, 1));
      else if (mode == M_RAND)
        in_valid = ($urandom_range(0, 3) != 0);
      else if (mode == M_STALL && s.l == 0 && s.n == 0
               && s.i == 2 && hold > 0) begin
        in_valid = 1'b0;
        hold--;
      end else
        in_valid = 1'b1;
      if (mode == M_RAND) start = 1'($urandom_range(0, 1));
      #1;
      ef = {1'b1, 1'(s.l), 1'(s.k == K_CLR),
            1'(s.k == K_MAC && in_valid), 1'(s.k == K_ACT),
            1'(s.k == K_WR), 2'b00};
      chk("flags", flags(), ef);
      chk("neuron", neuron_idx, s.n);
      chk("waddr", weight_addr, s.a);
      if (s.k == K_CLR || s.k == K_MAC) chk("in_idx", in_idx, s.i);
      if (s.k == K_MAC && !in_valid) stalls++;
      else void'(q.pop_front());
      cyc++;
      if (mode == M_ABORT && s.k == K_MAC && s.l == 1 && s.n == 1) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_out", all_out(), 32'd0);
        for (int k = 0; k < 4; k++) begin
          @(posedge clk); #1;
          chk("abort_nodone", {30'd0, done, busy}, 32'd0);
        end
        cut = 1;
      end else if (mode == M_RST && s.k == K_ACT && s.l == 0) begin
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst", all_out(), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle_chk(5, "post_rst_idle");
        cut = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (!cut) begin
      chk("run_left", q.size(), 0);
      chk("cycles", cyc, RUN_CYC + stalls);
      if (mode == M_STALL) chk("stalls", stalls, 5);
      chk("done_flags", flags(), 8'b0000_0011);
      chk("done_addr", weight_addr, N_W);
      @(posedge clk); #1;
      chk("done_hold", flags(), 8'b0000_0001);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", all_out(), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_chk(10, "idle");
    run(M_NOM);
    repeat (3) begin
      @(posedge clk); #1;
      chk("done_keep", flags(), 8'b0000_0001);
    end
    run(M_NOM);
    run(M_STALL);
    run(M_ABORT);
    run(M_NOM);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort", all_out(), 32'd0);
    idle_chk(3, "start_abort_idle");
    run(M_RST);
    for (int r = 0; r < 4; r++) run(M_RAND);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
